// File: rtl/pio_led_chaser_master_pkg.sv
// Shared definitions for the LED chaser Avalon-MM master: FSM states,
// PIO register word offsets and bus widths.
package pio_led_chaser_master_pkg;

  localparam int AVM_DW = 32;
  localparam int AVM_AW = 3;

  localparam logic [AVM_AW-1:0] PIO_DATA   = 3'd0;
  localparam logic [AVM_AW-1:0] PIO_DIR    = 3'd1;
  localparam logic [AVM_AW-1:0] PIO_OUTSET = 3'd4;
  localparam logic [AVM_AW-1:0] PIO_OUTCLR = 3'd5;

  typedef enum logic [2:0] {
    INIT_DIR   = 3'd0,
    WAIT_TICK  = 3'd1,
    WR_DATA    = 3'd2,
    RD_ADDR    = 3'd3,
    RD_CAPTURE = 3'd4
  } state_e;

endpackage

// File: rtl/pio_led_chaser_master_if.sv
// Avalon-MM bus between the chaser master and a PIO slave.
interface pio_led_chaser_master_if import pio_led_chaser_master_pkg::*; ();

  // Handshake: a transfer completes on a rising clk edge where chipselect=1 and
  // waitrequest=0; the master holds address/write_n/writedata stable until then.
  // For a read, readdata is valid exactly one cycle after the completing edge.
  logic [AVM_AW-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_write_n;
  logic [AVM_DW-1:0] avm_writedata;
  logic [AVM_DW-1:0] avm_readdata;
  logic              avm_waitrequest;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_readdata, avm_waitrequest
  );

endinterface

// File: rtl/pio_tick_div.sv
// Step-rate divider: counts 0..TICK_DIV-1, pulses tick at terminal count,
// and is forced back to 0 while hold is high.
module pio_tick_div #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic hold,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    tick    = 1'b0;
    count_d = count_q;
    if (hold) begin
      count_d = '0;
    end else if (count_q == TC) begin
      tick    = 1'b1;
      count_d = '0;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

endmodule

// File: rtl/pio_led_chaser_master.sv
// Avalon-MM master that sets a PIO to output, then writes a rotating LED
// pattern once per tick and reads it back to flag mismatches.
module pio_led_chaser_master import pio_led_chaser_master_pkg::*; #(
  parameter int               TICK_DIV = 50_000_000,
  parameter int               LED_W    = 4,
  parameter logic [LED_W-1:0] INIT_PAT = LED_W'(1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  pio_led_chaser_master_if.master avm,
  output logic [LED_W-1:0]        pattern,
  output logic                    mismatch,
  output logic                    busy,
  output state_e                  state_dbg
);

  state_e              state_q, state_d;
  logic                cs_q, cs_d;
  logic                wr_n_q, wr_n_d;
  logic [AVM_AW-1:0]   addr_q, addr_d;
  logic [AVM_DW-1:0]   wdata_q, wdata_d;
  logic [LED_W-1:0]    pattern_q, pattern_d, next_pat;
  logic                mism_q, mism_d;
  logic                accept, tick, hold, cap_err;
  logic                unused_readdata;

  // A zero pattern only exists before the first data write.
  assign next_pat = (pattern_q == '0) ? INIT_PAT
                                      : {pattern_q[LED_W-2:0], pattern_q[LED_W-1]};
  assign accept   = cs_q & ~avm.avm_waitrequest;
  assign hold     = (state_q != WAIT_TICK) | ~enable;
  assign cap_err  = (state_q == RD_CAPTURE) &&
                    (avm.avm_readdata[LED_W-1:0] != pattern_q);
  assign unused_readdata = ^avm.avm_readdata[AVM_DW-1:LED_W];

  pio_tick_div #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .hold    (hold),
    .tick    (tick)
  );

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    mism_d    = mism_q | cap_err;
    case (state_q)
      INIT_DIR:   if (accept) state_d = WR_DATA;
      WR_DATA: begin
        if (accept) begin
          pattern_d = wdata_q[LED_W-1:0];
          state_d   = RD_ADDR;
        end
      end
      RD_ADDR:    if (accept) state_d = RD_CAPTURE;
      RD_CAPTURE: state_d = WAIT_TICK;
      WAIT_TICK:  if (tick) state_d = WR_DATA;
      default:    state_d = INIT_DIR;
    endcase

    // Bus outputs are registered from the next state, so a stalled state
    // keeps every request field unchanged.
    cs_d    = 1'b0;
    wr_n_d  = 1'b1;
    addr_d  = PIO_DATA;
    wdata_d = '0;
    case (state_d)
      INIT_DIR: begin
        cs_d                 = 1'b1;
        wr_n_d               = 1'b0;
        addr_d               = PIO_DIR;
        wdata_d[LED_W-1:0]   = '1;
      end
      WR_DATA: begin
        cs_d                 = 1'b1;
        wr_n_d               = 1'b0;
        wdata_d[LED_W-1:0]   = next_pat;
      end
      RD_ADDR: begin
        cs_d                 = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= INIT_DIR;
      cs_q      <= 1'b0;
      wr_n_q    <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      pattern_q <= '0;
      mism_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cs_q      <= cs_d;
      wr_n_q    <= wr_n_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      pattern_q <= pattern_d;
      mism_q    <= mism_d;
    end
  end

  assign avm.avm_chipselect = cs_q;
  assign avm.avm_write_n    = wr_n_q;
  assign avm.avm_address    = addr_q;
  assign avm.avm_writedata  = wdata_q;

  assign pattern   = pattern_q;
  assign mismatch  = mism_q | cap_err;
  assign busy      = cs_q;
  assign state_dbg = state_q;

endmodule
